// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg - shared types and helpers for the universal shift register.
//
// Contents:
//   mode_e         3-bit command code (HOLD..RSVD)
//   state_e        control FSM states (IDLE, SHIFT, DONE)
//   is_shift_mode  true for commands that run shift steps
//
// Optional feature macro: ROTATE_EN. When it is undefined, ROL/ROR are not
// shift modes, so the top treats them as reserved commands.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ASR  = 3'd4,
        ROL  = 3'd5,
        ROR  = 3'd6,
        RSVD = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_mode(input mode_e m);
        case (m)
            SHL, SHR, ASR: return 1'b1;
`ifdef ROTATE_EN
            ROL, ROR:      return 1'b1;
`endif
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/univ_shift_step.sv
// univ_shift_step - combinational single-step shift/rotate datapath.
//
// Ports:
//   q       in   WIDTH  current stored word
//   mode    in   3      command code (mode_e encoding)
//   ser_in  in   1      fill bit for SHL/SHR
//   q_next  out  WIDTH  word after one step
//   out_bit out  1      bit leaving the word on this step
//
// Optional feature macro: ROTATE_EN. Without it no rotate logic is built and
// ROL/ROR fall into the pass-through default.
module univ_shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode_e'(mode))
            SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
`ifdef ROTATE_EN
            ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg - WIDTH-bit universal shift register with start/busy/done
// command handshake. Commands: HOLD, LOAD, SHL, SHR, ASR, ROL, ROR, reserved.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      command strobe, accepted only in IDLE
//   mode       in   3      command code, sampled with start
//   amt        in   AMT_W  step count (clamped to WIDTH), sampled with start
//   load_data  in   WIDTH  parallel load value, sampled with start
//   ser_in     in   1      fill bit, sampled on every shift step
//   q          out  WIDTH  stored word
//   ser_out    out  1      bit shifted out on the most recent step
//   busy       out  1      shift steps in progress
//   done       out  1      one-cycle completion pulse
//   err        out  1      with done: command was illegal
//
// Optional feature macro: ROTATE_EN (rotate modes 5/6; reserved otherwise).
//
// state | meaning
// IDLE  | waiting for start; LOAD/HOLD/empty/reserved complete directly
// SHIFT | one step per edge, cnt counts remaining steps down to 1
// DONE  | done (and err) high for one cycle, then back to IDLE
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_e           state, state_nxt;
    mode_e            mode_r, mode_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt, step_q;
    logic             so_nxt, step_out;
    logic             err_r, err_nxt;
    mode_e            mode_in;

    assign mode_in = mode_e'(mode);

    univ_shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q),
        .mode    (mode_r),
        .ser_in  (ser_in),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= HOLD;
            cnt     <= '0;
            q       <= '0;
            ser_out <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode_r  <= mode_nxt;
            cnt     <= cnt_nxt;
            q       <= q_nxt;
            ser_out <= so_nxt;
            err_r   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        cnt_nxt   = cnt;
        q_nxt     = q;
        so_nxt    = ser_out;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode_in == LOAD) begin
                        q_nxt     = load_data;
                        state_nxt = DONE;
                    end else if (is_shift_mode(mode_in) && (amt != '0)) begin
                        mode_nxt  = mode_in;
                        cnt_nxt   = (amt > AMT_MAX) ? AMT_MAX : amt;
                        state_nxt = SHIFT;
                    end else begin
                        // HOLD and empty shifts are legal no-ops; anything
                        // else here (reserved, or rotate when not built) is illegal.
                        err_nxt   = !(mode_in == HOLD || is_shift_mode(mode_in));
                        state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                q_nxt   = step_q;
                so_nxt  = step_out;
                cnt_nxt = cnt - AMT_ONE;
                if (cnt == AMT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign err  = err_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with a cycle scoreboard.
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

`ifdef ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [3:0] amt = 4'd0;
    logic [7:0] load_data = 8'h00;
    logic       ser_in = 1'b0;
    logic [7:0] q;
    logic       ser_out, busy, done, err;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_q = 8'h00;
    logic       m_so = 1'b0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amt       (amt),
        .load_data (load_data),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic e, input string tag);
        exp_t x;
        x.q = m_q; x.so = m_so; x.busy = b; x.done = d; x.err = e; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic model_step(input logic [2:0] md, input logic si);
        logic signed [7:0] s;
        s = m_q;
        case (md)
            3'd2: begin m_so = m_q[7]; m_q = (m_q << 1) | {7'd0, si}; end
            3'd3: begin m_so = m_q[0]; m_q = (m_q >> 1) | {si, 7'd0}; end
            3'd4: begin m_so = m_q[0]; m_q = s >>> 1; end
            3'd5: begin m_so = m_q[7]; m_q = (m_q << 1) | (m_q >> 7); end
            3'd6: begin m_so = m_q[0]; m_q = (m_q >> 1) | (m_q << 7); end
            default: ;
        endcase
    endtask

    // Issue one command; ovl_at>0 fires a stray LOAD start after that sample.
    task automatic issue(input logic [2:0] md, input logic [3:0] a, input logic [7:0] ld,
                         input logic si, input string tag, input int ovl_at);
        bit is_shift, is_rsvd;
        int n, idx;
        exp_t e;
        is_shift = (md >= 3'd2 && md <= 3'd4) || (ROT_EN && (md == 3'd5 || md == 3'd6));
        is_rsvd  = (md == 3'd7) || (!ROT_EN && (md == 3'd5 || md == 3'd6));
        if (md == 3'd1) begin
            m_q = ld;
            push(1'b0, 1'b1, 1'b0, {tag, " e0"});
        end else if (is_shift && a != 4'd0) begin
            n = (a > 4'd8) ? 8 : int'(a);
            push(1'b1, 1'b0, 1'b0, {tag, " e0"});
            for (int k = 1; k <= n; k++) begin
                model_step(md, si);
                push(k < n, k == n, 1'b0, $sformatf("%s e%0d", tag, k));
            end
        end else begin
            push(1'b0, 1'b1, is_rsvd, {tag, " e0"});
        end
        push(1'b0, 1'b0, 1'b0, {tag, " idle"});

        @(negedge clk);
        start = 1'b1; mode = md; amt = a; load_data = ld; ser_in = si;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, " q"}, q, e.q);
            chk({e.tag, " ser_out"}, {7'd0, ser_out}, {7'd0, e.so});
            chk({e.tag, " busy"}, {7'd0, busy}, {7'd0, e.busy});
            chk({e.tag, " done"}, {7'd0, done}, {7'd0, e.done});
            chk({e.tag, " err"}, {7'd0, err}, {7'd0, e.err});
            idx++;
            if (sb.size() > 0) begin
                if (idx == ovl_at) begin
                    @(negedge clk);
                    start = 1'b1; mode = 3'd1; load_data = 8'hFF; amt = 4'd1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("reset q", q, 8'h00);
        chk("reset busy", {7'd0, busy}, 8'h00);
        chk("reset done", {7'd0, done}, 8'h00);
        chk("reset err", {7'd0, err}, 8'h00);
        chk("reset ser_out", {7'd0, ser_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd1, 4'd0, 8'hA5, 1'b0, "load_a5", 0);
        issue(3'd1, 4'd0, 8'h81, 1'b0, "load_81", 0);
        issue(3'd2, 4'd3, 8'h00, 1'b1, "shl3", 0);
        issue(3'd1, 4'd0, 8'h90, 1'b0, "load_90", 0);
        issue(3'd4, 4'd2, 8'h00, 1'b0, "asr2", 0);
        issue(3'd3, 4'd1, 8'h00, 1'b0, "shr1", 0);
        issue(3'd1, 4'd0, 8'h01, 1'b0, "load_01", 0);
        issue(3'd6, 4'd9, 8'h00, 1'b0, "ror9", 0);
        issue(3'd5, 4'd3, 8'h00, 1'b0, "rol3", 0);
        issue(3'd7, 4'd2, 8'h55, 1'b1, "rsvd", 0);
        issue(3'd2, 4'd0, 8'h00, 1'b1, "shl0", 0);
        issue(3'd0, 4'd4, 8'h33, 1'b1, "hold", 0);
        issue(3'd1, 4'd0, 8'h3C, 1'b0, "load_3c", 0);
        issue(3'd3, 4'd4, 8'h00, 1'b1, "shr4_ovl", 1);
        issue(3'd2, 4'd15, 8'h00, 1'b0, "shl15", 0);
        issue(3'd1, 4'd0, 8'hC3, 1'b0, "load_c3", 0);

        // Reset in the middle of a shift command.
        @(negedge clk);
        start = 1'b1; mode = 3'd2; amt = 4'd5; ser_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-rst busy", {7'd0, busy}, 8'h01);
        rst = 1'b1;
        #1;
        chk("midrst q", q, 8'h00);
        chk("midrst busy", {7'd0, busy}, 8'h00);
        chk("midrst done", {7'd0, done}, 8'h00);
        chk("midrst ser_out", {7'd0, ser_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post-rst done", {7'd0, done}, 8'h00);
            chk("post-rst busy", {7'd0, busy}, 8'h00);
        end
        m_q = 8'h00; m_so = 1'b0;
        issue(3'd1, 4'd0, 8'h5A, 1'b0, "load_after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
